output_display: RTL and testbench
=================================

OUTPUT_DISPLAY -- requirements
Module: output_display

Interface
REQ-001 The parameter list SHALL be: SCAN_DIV, default 16, clock cycles each digit stays selected (must be >= 2).
REQ-002 The port i_clk SHALL be: input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-003 The port i_rst_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 The port i_load SHALL be: input, 1 bit, a capture strobe sampled on the clock edge.
REQ-005 The port i_data SHALL be: input, 8 bits, the bus word to display.
REQ-006 The port o_busy SHALL be: output, 1 bit, high while a BCD conversion is in progress.
REQ-007 The port o_value SHALL be: output, 8 bits, the last captured word.
REQ-008 The port o_seg SHALL be: output, 7 bits, active-high segments {g,f,e,d,c,b,a}.
REQ-009 The port o_an SHALL be: output, 4 bits, active-low one-hot digit select, where bit 0 is the ones digit.

Function
REQ-010 The FSM SHALL have two states, IDLE and CONV.
REQ-011 In IDLE, i_load=1 SHALL capture i_data into o_value, set o_busy, and enter CONV on the same edge.
REQ-012 CONV SHALL run exactly 8 cycles, performing one double-dabble shift per cycle (add 3 to any BCD nibble >= 5 before the shift).
REQ-013 On the 8th CONV edge, the hundreds, tens and ones digits SHALL update atomically, o_busy SHALL clear, and the FSM SHALL return to IDLE.
REQ-014 If i_load is asserted at edge N, the new digits SHALL be visible from edge N+8 and o_busy SHALL be high for exactly 8 cycles.
REQ-015 i_load during CONV SHALL be ignored, with no queuing; i_load on the edge that returns to IDLE SHALL also be ignored.
REQ-016 The displayed digits SHALL hold their previous values throughout CONV.
REQ-017 A prescaler SHALL count 0..SCAN_DIV-1; on wrap, the digit index SHALL advance 0,1,2,3,0.
REQ-018 Exactly one o_an bit SHALL be low at any time outside reset.
REQ-019 Leading-zero blanking: hundreds SHALL be blanked when 0, tens SHALL be blanked when hundreds and tens are both 0, and ones SHALL always be shown.
REQ-020 A blanked digit SHALL drive o_seg=0 while its anode is still scanned.
REQ-021 Digit 3 SHALL be blank unless REQ-026 applies.
REQ-022 Segment codes SHALL be the standard 0-9 set, for example 0=7'h3F, 1=7'h06 and 8=7'h7F.

Reset
REQ-023 While i_rst_n=0, the outputs SHALL be: o_busy=0, o_value=0, o_seg=0 and o_an=4'b1111; the FSM SHALL be in IDLE, the prescaler and digit index SHALL be 0, and all digits SHALL be 0.
REQ-024 On the first edge after reset release, digit 0 SHALL be selected and display "0" (o_seg=7'h3F).
REQ-025 A reset asserted mid-CONV SHALL abort the conversion; no partial digits SHALL ever become visible.

Configuration
REQ-026 When OUTPUT_DISPLAY_SIGNED_EN is defined, i_data SHALL be treated as two's complement.
- The magnitude SHALL be converted; -128 SHALL display 128.
- Digit 3 SHALL show minus (o_seg=7'h40) when the value is negative, and blank otherwise.
- o_value SHALL keep the raw captured word.
REQ-027 When OUTPUT_DISPLAY_SIGNED_EN is not defined, i_data SHALL be unsigned (0..255) and digit 3 SHALL be permanently blank.
REQ-028 Latency and o_busy timing SHALL be identical in both builds.

Structure
REQ-029 Package output_display_pkg SHALL hold the state enum (IDLE, CONV), the segment constants for 0-9, blank and minus, and the digit count 4.
REQ-030 One combinational sub-module, seg7_decode, SHALL map a 4-bit BCD digit plus a blank flag to o_seg.
REQ-031 The FSM, double-dabble datapath and scan counter SHALL reside in output_display.

Verification
REQ-032 Reset held for 3 cycles, then released -> o_an=1111 and o_seg=0 during reset; then o_an=1110 and o_seg=7'h3F.
REQ-033 i_load=1, i_data=8'd237 -> o_busy high for 8 cycles; then scanned digits 7, 3, 2 and blank; o_value=8'hED.
REQ-034 i_data=8'd5 -> hundreds and tens blanked (o_seg=0 on o_an=1011 and 1101); ones shows 7'h6D.
REQ-035 i_load pulses at CONV cycles 1 and 8 with different data -> both ignored; the display reflects only the first word.
REQ-036 Reset asserted at CONV cycle 4 -> after release, display "0", o_busy=0, o_value=0.
REQ-037 SIGNED build: i_data=8'h80 -> digits 8, 2, 1 and digit 3 shows 7'h40; unsigned build: the same input shows 128 with digit 3 blank.

Source files
------------

// File: rtl/output_display_pkg.sv
// Shared types and constants for the output_display BCD/7-segment block.
package output_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam int NUM_DIGITS  = 4;
  localparam int CONV_CYCLES = 8;

  // Segment codes, active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  function automatic logic [11:0] dabbleStep(input logic [11:0] bcd, input logic bitIn);
    logic [11:0] adj;
    for (int n = 0; n < 3; n++) begin
      adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
    end
    return {adj[10:0], bitIn};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment decoder with a blanking override.
module seg7_decode
  import output_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/output_display.sv
// Captures a byte, converts it to BCD over 8 cycles and scans it onto a 4-digit display.
// Define OUTPUT_DISPLAY_SIGNED_EN to treat the input as two's complement with a minus on digit 3.
module output_display #(
  parameter int SCAN_DIV = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic [7:0] o_value,
  output logic [6:0] o_seg,
  output logic [3:0] o_an
);
  import output_display_pkg::*;

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(NUM_DIGITS);

  state_e          state_q, state_d;
  logic [2:0]      convCnt_q;
  logic [7:0]      bin_q;
  logic [11:0]     bcd_q;
  logic [11:0]     bcdNext;
  logic [7:0]      value_q;
  logic            neg_q;
  logic [3:0]      hund_q, tens_q, ones_q;
  logic            dispNeg_q;
  logic [PW-1:0]   scanCnt_q;
  logic [DW-1:0]   digitIdx_q;
  logic            scanEn_q;
  logic [7:0]      loadMag;
  logic            loadNeg;
  logic            startConv;
  logic            lastConv;
  logic [3:0]      selDigit;
  logic            selBlank;
  logic [6:0]      decSeg;

`ifdef OUTPUT_DISPLAY_SIGNED_EN
  // -128 negates to 8'h80, which reads as 128 unsigned: exactly the magnitude wanted.
  assign loadNeg = i_data[7];
  assign loadMag = i_data[7] ? (~i_data + 8'd1) : i_data;
`else
  assign loadNeg = 1'b0;
  assign loadMag = i_data;
`endif

  assign startConv = (state_q == IDLE) && i_load;
  assign lastConv  = (state_q == CONV) && (convCnt_q == 3'(CONV_CYCLES - 1));
  assign bcdNext   = dabbleStep(bcd_q, bin_q[7]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_load)   state_d = CONV;
      CONV:    if (lastConv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q == CONV);
  end

  // Working registers shift every CONV cycle; visible digits only change on the final one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q   <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      convCnt_q <= '0;
      neg_q     <= 1'b0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      dispNeg_q <= 1'b0;
    end else if (startConv) begin
      value_q   <= i_data;
      bin_q     <= loadMag;
      bcd_q     <= '0;
      convCnt_q <= '0;
      neg_q     <= loadNeg;
    end else if (state_q == CONV) begin
      bin_q     <= {bin_q[6:0], 1'b0};
      bcd_q     <= bcdNext;
      convCnt_q <= convCnt_q + 3'd1;
      if (lastConv) begin
        hund_q    <= bcdNext[11:8];
        tens_q    <= bcdNext[7:4];
        ones_q    <= bcdNext[3:0];
        dispNeg_q <= neg_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scanEn_q   <= 1'b0;
      scanCnt_q  <= '0;
      digitIdx_q <= '0;
    end else begin
      scanEn_q <= 1'b1;
      if (scanCnt_q == PW'(SCAN_DIV - 1)) begin
        scanCnt_q  <= '0;
        digitIdx_q <= digitIdx_q + DW'(1);
      end else begin
        scanCnt_q <= scanCnt_q + PW'(1);
      end
    end
  end

  always_comb begin
    selDigit = 4'd0;
    selBlank = 1'b1;
    case (digitIdx_q)
      2'd0: begin selDigit = ones_q; selBlank = 1'b0; end
      2'd1: begin selDigit = tens_q; selBlank = (hund_q == 4'd0) && (tens_q == 4'd0); end
      2'd2: begin selDigit = hund_q; selBlank = (hund_q == 4'd0); end
      default: begin selDigit = 4'd0; selBlank = 1'b1; end
    endcase
  end

  seg7_decode u_decode (
    .digit_i (selDigit),
    .blank_i (selBlank),
    .seg_o   (decSeg)
  );

  always_comb begin
    o_an  = 4'b1111;
    o_seg = SEG_BLANK;
    if (scanEn_q) begin
      o_an = ~(4'b0001 << digitIdx_q);
      if (digitIdx_q == 2'd3) o_seg = dispNeg_q ? SEG_MINUS : SEG_BLANK;
      else                    o_seg = decSeg;
    end
  end

  assign o_value = value_q;

endmodule

// File: tb/tb_output_display.sv
// Scoreboard bench for output_display: random loads against a decimal-arithmetic reference model.
// Honours OUTPUT_DISPLAY_SIGNED_EN the same way as the design.
module tb_output_display;

  localparam int SD = 4;

  typedef struct packed {
    logic [7:0]      value;
    logic [3:0][6:0] seg;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       i_load;
  logic [7:0] i_data;
  logic       o_busy;
  logic [7:0] o_value;
  logic [6:0] o_seg;
  logic [3:0] o_an;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   edgeCnt = 0;
  int   k;
  int   freeEdge = 0;

  logic [3:0][6:0] dispSegs;
  logic [7:0]      expValue;
  int              busyRun;
  logic            prevBusy;
  logic            stuck;
  exp_t            popped;
  int              expIdx;
  logic [3:0]      expAn;

  output_display #(.SCAN_DIV(SD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_load  (i_load),
    .i_data  (i_data),
    .o_busy  (o_busy),
    .o_value (o_value),
    .o_seg   (o_seg),
    .o_an    (o_an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  function automatic logic [6:0] digitSeg(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Decimal reference: split the (signed or unsigned) value into hundreds/tens/ones by division.
  function automatic exp_t model(input logic [7:0] d);
    exp_t e;
    int   sv, mag, h, t, o;
    logic neg;
`ifdef OUTPUT_DISPLAY_SIGNED_EN
    sv = d[7] ? int'(d) - 256 : int'(d);
`else
    sv = int'(d);
`endif
    neg = (sv < 0);
    mag = neg ? -sv : sv;
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    e.value  = d;
    e.seg[0] = digitSeg(o);
    e.seg[1] = (h == 0 && t == 0) ? 7'h00 : digitSeg(t);
    e.seg[2] = (h == 0) ? 7'h00 : digitSeg(h);
    e.seg[3] = neg ? 7'h40 : 7'h00;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic load, input logic [7:0] data);
    int nextEdge;
    @(negedge clk);
    #1;
    i_load = load;
    i_data = data;
    nextEdge = edgeCnt + 1;
    if (load && rst_n && nextEdge >= freeEdge) begin
      sb.push_back(model(data));
      freeEdge = nextEdge + 9;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'($urandom));
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    #1;
    rst_n    = 1'b0;
    i_load   = 1'b0;
    freeEdge = 0;
    repeat (n) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: retire a scoreboard entry each time a conversion finishes, check the scan every cycle.
  initial begin
    dispSegs = model(8'd0).seg;
    expValue = 8'd0;
    busyRun  = 0;
    prevBusy = 1'b0;
    stuck    = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset_an", 32'(o_an), 32'hF);
      checkOutput("reset_seg", 32'(o_seg), 32'h0);
      checkOutput("reset_busy", 32'(o_busy), 32'h0);
      checkOutput("reset_value", 32'(o_value), 32'h0);
      sb.delete();
      dispSegs = model(8'd0).seg;
      expValue = 8'd0;
      busyRun  = 0;
      prevBusy = 1'b0;
      stuck    = 1'b0;
    end else begin
      if (o_busy && !prevBusy && sb.size() > 0) expValue = sb[0].value;
      if (o_busy) busyRun++;
      if (!o_busy && prevBusy) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          popped = sb.pop_front();
          checkOutput("busy_len", 32'(busyRun), 32'd8);
          dispSegs = popped.seg;
        end
        busyRun = 0;
      end
      if (busyRun > 12 && !stuck) begin
        checkOutput("busy_timeout", 32'(busyRun), 32'd8);
        stuck = 1'b1;
      end
      prevBusy = o_busy;
      checkOutput("value", 32'(o_value), 32'(expValue));
      expIdx = (k / SD) % 4;
      expAn  = (k == 0) ? 4'hF : ~(4'b0001 << expIdx);
      checkOutput("an", 32'(o_an), 32'(expAn));
      if (k != 0) checkOutput("seg", 32'(o_seg), 32'(dispSegs[expIdx]));
    end
  end

  initial begin
    int waited;
    rst_n  = 1'b0;
    i_load = 1'b0;
    i_data = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(4 * SD + 2);

    applyStimulus(1'b1, 8'd237);
    idle(9 + 4 * SD + 2);

    applyStimulus(1'b1, 8'd5);
    idle(9 + 4 * SD + 2);

    // Loads on the first CONV edge and on the returning edge must both be dropped.
    applyStimulus(1'b1, 8'd42);
    applyStimulus(1'b1, 8'd199);
    idle(6);
    applyStimulus(1'b1, 8'd250);
    idle(4 * SD + 4);

    applyStimulus(1'b1, 8'd163);
    idle(3);
    doReset(2);
    idle(4 * SD + 4);

    applyStimulus(1'b1, 8'h80);
    idle(9 + 4 * SD + 2);

    for (int i = 0; i < 80; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom));
    end
    idle(9 + 4 * SD + 2);

    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      idle(1);
      waited++;
    end
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
